// File: rtl/vend_seq_ctrl.sv
// Coin vending sequencing controller.
// Arbitrates the 5 Rs / 10 Rs acceptors, accumulates credit in 5 Rs units,
// runs the dispenser handshake with a timeout, and pays change one coin at a
// time through the hopper. Every output is a register loaded from the
// next-value logic below.
module vend_seq_ctrl #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int CW         = 3,
    parameter int VEND_TO    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin5_req,
    input  logic          coin10_req,
    output logic          coin5_ack,
    output logic          coin10_ack,
    output logic          coin_rej,
    input  logic          cancel,
    output logic          vend_req,
    input  logic          vend_done,
    output logic          chg_req,
    input  logic          chg_done,
    output logic [CW-1:0] credit,
    output logic          busy,
    output logic          vend_fault
);

    localparam int TW = $clog2(VEND_TO + 1);

    localparam logic [TW-1:0] TO_LAST   = TW'(VEND_TO - 1);
    localparam logic [CW:0]   MAX_W     = (CW + 1)'(MAX_CREDIT);
    localparam logic [CW:0]   PRICE_W   = (CW + 1)'(PRICE);
    localparam logic [CW-1:0] PRICE_C   = CW'(PRICE);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nxt;
    logic [CW-1:0] credit_nxt;
    logic          coin5_ack_nxt;
    logic          coin10_ack_nxt;
    logic          coin_rej_nxt;
    logic          vend_req_nxt;
    logic          chg_req_nxt;
    logic          vend_fault_nxt;
    logic          busy_nxt;

    // Widened sum so a full-scale credit plus a 10 Rs coin cannot wrap.
    function automatic logic [CW:0] add_credit(input logic [CW-1:0] c,
                                               input logic [1:0]    v);
        return {1'b0, c} + {{(CW - 1){1'b0}}, v};
    endfunction

    // Floor-protected subtraction: credit is left alone if it would underflow.
    function automatic logic [CW-1:0] sub_credit(input logic [CW-1:0] c,
                                                 input logic [CW-1:0] d);
        return (c >= d) ? (c - d) : c;
    endfunction

    // A request counts only while its own ack is low, so a held req is not
    // counted twice while the acceptor is still dropping it.
    logic          el10;
    logic          el5;
    logic          grant10;
    logic          grant5;
    logic          grant_any;
    logic [1:0]    grant_val;
    logic [CW:0]   sum;
    logic          fits;
    logic          cancel_hit;
    logic          done_hit;
    logic          timeout_hit;
    logic          chg_hit;
    logic [CW-1:0] vend_rem;

    assign el10        = coin10_req && !coin10_ack;
    assign el5         = coin5_req && !coin5_ack;
    assign grant10     = el10;
    assign grant5      = el5 && !el10;
    assign grant_any   = grant10 || grant5;
    assign grant_val   = grant10 ? 2'd2 : (grant5 ? 2'd1 : 2'd0);
    assign sum         = add_credit(credit, grant_val);
    assign fits        = (sum <= MAX_W);
    assign cancel_hit  = (state == S_COLLECT) && cancel && (credit != '0);
    assign done_hit    = (state == S_VEND) && vend_req && vend_done;
    assign timeout_hit = (state == S_VEND) && vend_req && !vend_done && (cnt == TO_LAST);
    assign chg_hit     = (state == S_CHANGE) && chg_req && chg_done;
    assign vend_rem    = sub_credit(credit, PRICE_C);

    // State and registered outputs; reset discards credit and aborts handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_COLLECT;
            cnt        <= '0;
            credit     <= '0;
            coin5_ack  <= 1'b0;
            coin10_ack <= 1'b0;
            coin_rej   <= 1'b0;
            vend_req   <= 1'b0;
            chg_req    <= 1'b0;
            vend_fault <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            credit     <= credit_nxt;
            coin5_ack  <= coin5_ack_nxt;
            coin10_ack <= coin10_ack_nxt;
            coin_rej   <= coin_rej_nxt;
            vend_req   <= vend_req_nxt;
            chg_req    <= chg_req_nxt;
            vend_fault <= vend_fault_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state selection; cancel outranks coin acceptance, vend_done outranks timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: begin
                if (cancel_hit) begin
                    state_nxt = S_CHANGE;
                end else if (grant_any && fits && (sum >= PRICE_W)) begin
                    state_nxt = S_VEND;
                end
            end
            S_VEND: begin
                if (done_hit) begin
                    state_nxt = (vend_rem != '0) ? S_CHANGE : S_COLLECT;
                end else if (timeout_hit) begin
                    state_nxt = S_CHANGE;
                end
            end
            S_CHANGE: begin
                if (chg_hit && (credit <= ONE_C)) begin
                    state_nxt = S_COLLECT;
                end else if (credit == '0) begin
                    state_nxt = S_COLLECT;
                end
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    // Next values of the registered outputs, credit and timeout counter.
    always_comb begin
        coin5_ack_nxt  = 1'b0;
        coin10_ack_nxt = 1'b0;
        coin_rej_nxt   = 1'b0;
        vend_req_nxt   = 1'b0;
        chg_req_nxt    = 1'b0;
        vend_fault_nxt = 1'b0;
        credit_nxt     = credit;
        cnt_nxt        = cnt;
        case (state)
            S_COLLECT: begin
                if (cancel_hit) begin
                    coin_rej_nxt = grant_any;
                    chg_req_nxt  = 1'b1;
                end else if (grant_any) begin
                    if (fits) begin
                        coin10_ack_nxt = grant10;
                        coin5_ack_nxt  = grant5;
                        credit_nxt     = sum[CW-1:0];
                        if (sum >= PRICE_W) begin
                            vend_req_nxt = 1'b1;
                            cnt_nxt      = '0;
                        end
                    end else begin
                        coin_rej_nxt = 1'b1;
                    end
                end
            end
            S_VEND: begin
                coin_rej_nxt = grant_any;
                if (done_hit) begin
                    credit_nxt  = vend_rem;
                    chg_req_nxt = (vend_rem != '0);
                end else if (timeout_hit) begin
                    vend_fault_nxt = 1'b1;
                    chg_req_nxt    = (credit != '0);
                end else begin
                    vend_req_nxt = 1'b1;
                    cnt_nxt      = cnt + 1'b1;
                end
            end
            S_CHANGE: begin
                coin_rej_nxt = grant_any;
                if (chg_hit) begin
                    credit_nxt = sub_credit(credit, ONE_C);
                end else begin
                    chg_req_nxt = (credit != '0);
                end
            end
            default: begin
                credit_nxt = '0;
            end
        endcase
        busy_nxt = (state_nxt != S_COLLECT);
    end

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Bench for vend_seq_ctrl: a cycle-by-cycle vector table applied to two
// instances (PRICE=3 and PRICE=7), with expected outputs queued on drive and
// popped after the following clock edge.
module tb_vend_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Instance A: PRICE=3
    logic       a_c5, a_c10, a_cancel, a_vdone, a_cdone;
    logic       a_c5a, a_c10a, a_rej, a_vreq, a_creq, a_busy, a_flt;
    logic [2:0] a_cred;
    // Instance B: PRICE=7
    logic       b_c5, b_c10, b_cancel, b_vdone, b_cdone;
    logic       b_c5a, b_c10a, b_rej, b_vreq, b_creq, b_busy, b_flt;
    logic [2:0] b_cred;

    vend_seq_ctrl #(.PRICE(3), .MAX_CREDIT(7), .CW(3), .VEND_TO(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .coin5_req(a_c5), .coin10_req(a_c10),
        .coin5_ack(a_c5a), .coin10_ack(a_c10a), .coin_rej(a_rej),
        .cancel(a_cancel),
        .vend_req(a_vreq), .vend_done(a_vdone),
        .chg_req(a_creq), .chg_done(a_cdone),
        .credit(a_cred), .busy(a_busy), .vend_fault(a_flt)
    );

    vend_seq_ctrl #(.PRICE(7), .MAX_CREDIT(7), .CW(3), .VEND_TO(16)) u_dut_b (
        .clk(clk), .rst(rst),
        .coin5_req(b_c5), .coin10_req(b_c10),
        .coin5_ack(b_c5a), .coin10_ack(b_c10a), .coin_rej(b_rej),
        .cancel(b_cancel),
        .vend_req(b_vreq), .vend_done(b_vdone),
        .chg_req(b_creq), .chg_done(b_cdone),
        .credit(b_cred), .busy(b_busy), .vend_fault(b_flt)
    );

    // inputs: {coin5, coin10, cancel, vend_done, chg_done}
    // flags:  {c5_ack, c10_ack, rej, vend_req, chg_req, fault, busy}
    typedef struct packed {
        logic [6:0] flags;
        logic [2:0] cred;
    } out_t;

    typedef struct {
        int         dut;
        string      name;
        logic [4:0] in;
        out_t       exp;
    } vec_t;

    vec_t  tbl[$];
    out_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic add(input int dut, input string name, input logic [4:0] in,
                       input logic [6:0] flags, input int cred);
        vec_t v;
        v.dut  = dut;
        v.name = name;
        v.in   = in;
        v.exp  = '{flags: flags, cred: 3'(cred)};
        tbl.push_back(v);
    endtask

    function automatic out_t get_out(input int dut);
        out_t o;
        if (dut == 0) o = '{flags: {a_c5a, a_c10a, a_rej, a_vreq, a_creq, a_flt, a_busy}, cred: a_cred};
        else          o = '{flags: {b_c5a, b_c10a, b_rej, b_vreq, b_creq, b_flt, b_busy}, cred: b_cred};
        return o;
    endfunction

    // Drive one cycle of inputs, queue the expectation, check after the edge.
    task automatic step(input int dut, input string name, input logic [4:0] in, input out_t exp);
        out_t  want;
        out_t  got;
        string nm;
        {a_c5, a_c10, a_cancel, a_vdone, a_cdone} = (dut == 0) ? in : 5'b0;
        {b_c5, b_c10, b_cancel, b_vdone, b_cdone} = (dut == 1) ? in : 5'b0;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = get_out(dut);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut=%0d flags got=%b want=%b credit got=%0d want=%0d",
                     nm, dut, got.flags, want.flags, got.cred, want.cred);
        end
    endtask

    localparam logic [6:0] Z = 7'b0000000;

    initial begin
        a_c5 = 0; a_c10 = 0; a_cancel = 0; a_vdone = 0; a_cdone = 0;
        b_c5 = 0; b_c10 = 0; b_cancel = 0; b_vdone = 0; b_cdone = 0;

        // Exact price: 10 + 5 at PRICE=3, no change
        add(0, "exact_c10",  5'b01000, 7'b0100000, 2);
        add(0, "exact_c5",   5'b10000, 7'b1001001, 3);
        add(0, "exact_hold", 5'b00000, 7'b0001001, 3);
        add(0, "exact_done", 5'b00010, Z,          0);
        add(0, "exact_idle", 5'b00000, Z,          0);
        // Overpay: held coin10 counted once per ack, then one change coin
        add(0, "over_c10a",  5'b01000, 7'b0100000, 2);
        add(0, "over_hold",  5'b01000, Z,          2);
        add(0, "over_c10b",  5'b01000, 7'b0101001, 4);
        add(0, "over_done",  5'b00010, 7'b0000101, 1);
        add(0, "over_chg",   5'b00001, Z,          0);
        add(0, "over_late",  5'b00001, Z,          0);
        // Arbitration: coin10 wins, coin5 next cycle; coin during VEND refused
        add(0, "arb_both",   5'b11000, 7'b0100000, 2);
        add(0, "arb_c5",     5'b10000, 7'b1001001, 3);
        add(0, "arb_vend",   5'b00000, 7'b0001001, 3);
        add(0, "arb_busyrej",5'b01000, 7'b0011001, 3);
        add(0, "arb_done",   5'b00010, Z,          0);
        // Timeout: fault on the 16th edge after vend_req rose, full refund
        add(0, "to_c10",     5'b01000, 7'b0100000, 2);
        add(0, "to_c5",      5'b10000, 7'b1001001, 3);
        for (int k = 1; k <= 15; k++) add(0, $sformatf("to_wait%0d", k), 5'b00000, 7'b0001001, 3);
        add(0, "to_fault",   5'b00000, 7'b0000111, 3);
        add(0, "to_chg1",    5'b00001, 7'b0000001, 2);
        add(0, "to_rtz1",    5'b00011, 7'b0000101, 2);
        add(0, "to_chg2",    5'b00001, 7'b0000001, 1);
        add(0, "to_rtz2",    5'b00000, 7'b0000101, 1);
        add(0, "to_chg3",    5'b00001, Z,          0);
        add(0, "to_idle",    5'b00000, Z,          0);
        // Cancel beats a simultaneous coin5; cancel ignored in CHANGE and at credit 0
        add(0, "can_c10",    5'b01000, 7'b0100000, 2);
        add(0, "can_rej",    5'b10100, 7'b0010101, 2);
        add(0, "can_chg1",   5'b00001, 7'b0000001, 1);
        add(0, "can_ign",    5'b00100, 7'b0000101, 1);
        add(0, "can_chg2",   5'b00001, Z,          0);
        add(0, "can_zero",   5'b00100, Z,          0);
        // Saturation at PRICE=7: credit 6 + 10 Rs refused, then 5 Rs vends
        add(1, "sat_c10a",   5'b01000, 7'b0100000, 2);
        add(1, "sat_gap1",   5'b00000, Z,          2);
        add(1, "sat_c10b",   5'b01000, 7'b0100000, 4);
        add(1, "sat_gap2",   5'b00000, Z,          4);
        add(1, "sat_c10c",   5'b01000, 7'b0100000, 6);
        add(1, "sat_gap3",   5'b00000, Z,          6);
        add(1, "sat_rej",    5'b01000, 7'b0010000, 6);
        add(1, "sat_gap4",   5'b00000, Z,          6);
        add(1, "sat_c5",     5'b10000, 7'b1001001, 7);
        add(1, "sat_done",   5'b00010, Z,          0);

        // Reset state on both instances
        rst = 1'b1;
        step(0, "rst_a", 5'b00000, '{flags: Z, cred: 3'd0});
        step(1, "rst_b", 5'b00000, '{flags: Z, cred: 3'd0});
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i].dut, tbl[i].name, tbl[i].in, tbl[i].exp);

        // Reset in the middle of a CHANGE with credit 2
        step(0, "mr_c10",    5'b01000, '{flags: 7'b0100000, cred: 3'd2});
        step(0, "mr_cancel", 5'b00100, '{flags: 7'b0000101, cred: 3'd2});
        rst = 1'b1;
        step(0, "mr_rst1",   5'b00001, '{flags: Z, cred: 3'd0});
        step(0, "mr_rst2",   5'b00001, '{flags: Z, cred: 3'd0});
        rst = 1'b0;
        step(0, "mr_cdone",  5'b00001, '{flags: Z, cred: 3'd0});
        step(0, "mr_c5",     5'b10000, '{flags: 7'b1000000, cred: 3'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_seq_ctrl.md
Name: vend_seq_ctrl

Overview:
Sequencing controller for the coin vending path. It arbitrates two coin acceptors (5 Rs and 10 Rs slots) and accumulates credit in 5 Rs units. When credit reaches the price it drives a dispenser handshake, then pays out change one 5 Rs coin at a time through a hopper handshake. It also supports cancel/refund and recovers from a dispenser timeout by refunding full credit.

Parameters:
PRICE, 3, item price in 5 Rs units (3 = 15 Rs); legal range 1..MAX_CREDIT.
MAX_CREDIT, 7, credit saturation limit in 5 Rs units; must fit CW bits.
CW, 3, credit register width.
VEND_TO, 16, dispenser timeout in clk cycles counted from vend_req assertion; must be at least 2.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
coin5_req  in  1  5 Rs acceptor request, level
coin10_req  in  1  10 Rs acceptor request, level
coin5_ack  out  1  one-cycle accept pulse to 5 Rs acceptor
coin10_ack  out  1  one-cycle accept pulse to 10 Rs acceptor
coin_rej  out  1  one-cycle pulse: coin refused (saturation or busy)
cancel  in  1  user refund request, sampled in COLLECT only
vend_req  out  1  dispense request, level, held until vend_done or timeout
vend_done  in  1  dispenser completion, single-cycle or level
chg_req  out  1  request hopper to eject one 5 Rs coin
chg_done  in  1  hopper completion for current coin
credit  out  CW  current credit in 5 Rs units
busy  out  1  high in VEND or CHANGE
vend_fault  out  1  one-cycle pulse on dispenser timeout

Behaviour:
- Reset (sync, rst=1 at posedge): state=COLLECT; credit=0; timeout counter=0. All outputs 0: coin5_ack, coin10_ack, coin_rej, vend_req, chg_req, vend_fault, busy. Reset mid-operation aborts any handshake at once; credit is discarded.
- All outputs are registered. Each response appears on the edge after its cause is sampled.
- Coin eligibility: a request line is eligible only when req=1 and its own ack is 0 in the current cycle. This blocks double counting while the acceptor drops req.
- Arbitration: at most one coin per cycle. Fixed priority coin10 over coin5. The losing request stays pending and is served next eligible cycle.
- COLLECT:
  - Granted coin, credit+value <= MAX_CREDIT: the matching ack pulses, credit += value (1 or 2) on the same edge.
  - Granted coin, credit+value > MAX_CREDIT: coin_rej pulses, no ack, credit unchanged. The acceptor treats rej as a return and must drop req.
  - Transition to VEND when the updated credit >= PRICE. vend_req rises on that same edge and the timeout counter clears.
  - cancel=1 with credit>0 and no coin granted this cycle: go to CHANGE. cancel has priority over coin acceptance; a pending coin that cycle gets coin_rej.
  - cancel with credit=0: ignored.
- VEND:
  - vend_req held 1; counter increments each cycle.
  - Eligible coin requests are answered with coin_rej, never acked.
  - vend_done=1: vend_req drops and credit -= PRICE on that edge. Next state is CHANGE if the remaining credit > 0, else COLLECT.
  - counter reaches VEND_TO-1 without vend_done: vend_req drops, vend_fault pulses, credit unchanged (full refund), go to CHANGE.
  - vend_done and timeout in the same cycle: vend_done wins, no fault.
- CHANGE:
  - chg_req asserted while credit>0.
  - chg_done=1 with chg_req=1: credit -= 1 and chg_req drops for exactly one cycle (return-to-zero between coins).
  - When credit reaches 0, return to COLLECT with chg_req=0.
  - Coin requests are answered with coin_rej; cancel is ignored.
- busy = (state==VEND || state==CHANGE), registered alongside state.
- Arithmetic: credit is an unsigned CW-bit value and never wraps. Saturation is checked on a CW+1-bit sum, and subtraction happens only when credit >= operand.
- vend_done or chg_done arriving outside its own request window is ignored.

Test Plan:
- Reset: rst high 2 cycles mid-CHANGE with credit=2 -> next cycle all outputs 0, credit=0, state COLLECT; chg_done afterwards ignored.
- Exact price: coin10 then coin5 (PRICE=3) -> acks one cycle after each req, credit 2 then 3, vend_req rises with credit=3. vend_done -> credit 0, busy 0, chg_req never asserted.
- Overpay + change: coin10, coin10 -> credit 4, vend. After vend_done credit=1 -> chg_req=1; chg_done -> credit 0, return to COLLECT, exactly one change coin.
- Arbitration/saturation: coin5_req and coin10_req high together at credit 0 -> coin10_ack first, coin5_ack next eligible cycle (credit 3, VEND entered). Then PRICE=7, credit=6, coin10 -> coin_rej, credit stays 6.
- Timeout: credit 3, vend_done held 0 -> vend_fault pulses at cycle VEND_TO after vend_req rose. Three chg_req/chg_done handshakes follow, with one low cycle between each.
- Cancel: credit 2 in COLLECT, cancel with coin5_req the same cycle -> coin_rej, CHANGE entered. Two change coins, then COLLECT with credit 0.
